// File: rtl/uart_tx_fifo_ctrl.sv
// Transmit FIFO and frame launcher between the PicoBlaze output port and the UART transmitter.
// Bytes queue in a circular buffer and are launched one frame at a time, each retired on tx_done_tick.
//
// state  | meaning
// IDLE   | no frame in flight; launch when the FIFO holds a byte
// LAUNCH | pop head byte, present it with a one-cycle tx_start
// BUSY   | frame in flight; wait for tx_done_tick
module uart_tx_fifo_ctrl #(
  parameter int DBIT   = 8,
  parameter int ADDR_W = 4
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              wr,
  input  logic [DBIT-1:0]   w_data,
  input  logic              tx_done_tick,
  output logic              tx_start,
  output logic [DBIT-1:0]   tx_din,
  output logic              full,
  output logic              empty,
  output logic [ADDR_W:0]   count,
  output logic              busy,
  output logic              overflow
);

  localparam logic [ADDR_W:0] DEPTH = {1'b1, {ADDR_W{1'b0}}};

  typedef enum logic [1:0] {IDLE, LAUNCH, BUSY} state_t;

  state_t            state;
  logic [DBIT-1:0]   mem [2**ADDR_W];
  logic [ADDR_W-1:0] wr_ptr;
  logic [ADDR_W-1:0] rd_ptr;
  logic              push;
  logic              pop;

  assign full  = (count == DEPTH);
  assign empty = (count == '0);
  assign push  = wr & ~full;
  // The launched slot is freed immediately, so count excludes the in-flight byte.
  assign pop   = (state == LAUNCH) & ~empty;

  always_ff @(posedge clk) begin
    if (push) mem[wr_ptr] <= w_data;
  end

  always_ff @(posedge clk) begin
    if (!reset) begin
      wr_ptr   <= '0;
      rd_ptr   <= '0;
      count    <= '0;
      overflow <= 1'b0;
    end else begin
      if (push) wr_ptr <= wr_ptr + 1'b1;
      if (pop)  rd_ptr <= rd_ptr + 1'b1;
      case ({push, pop})
        2'b10:   count <= count + 1'b1;
        2'b01:   count <= count - 1'b1;
        default: ;
      endcase
      if (wr && full) overflow <= 1'b1;
    end
  end

  always_ff @(posedge clk) begin
    if (!reset) begin
      state    <= IDLE;
      tx_start <= 1'b0;
      tx_din   <= '0;
      busy     <= 1'b0;
    end else begin
      tx_start <= 1'b0;
      case (state)
        IDLE: begin
          if (!empty) state <= LAUNCH;
        end
        LAUNCH: begin
          tx_din   <= mem[rd_ptr];
          tx_start <= 1'b1;
          busy     <= 1'b1;
          state    <= BUSY;
        end
        BUSY: begin
          if (tx_done_tick) begin
            busy  <= 1'b0;
            state <= IDLE;
          end
        end
        default: state <= IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_uart_tx_fifo_ctrl.sv
// Directed bench for uart_tx_fifo_ctrl with a simple transmitter model answering each tx_start.
module tb_uart_tx_fifo_ctrl;

  logic       clk = 1'b0;
  logic       reset;
  logic       wr;
  logic [7:0] w_data;
  logic       tx_done_tick;
  logic       tx_start;
  logic [7:0] tx_din;
  logic       full;
  logic       empty;
  logic [4:0] count;
  logic       busy;
  logic       overflow;

  logic model_tick;
  logic spur_tick;
  logic stall;
  logic model_off;
  int   tx_delay;

  int n_cmp = 0;
  int n_bad = 0;

  logic [7:0] seen [$];
  logic       prev_start = 1'b0;
  int         dbl_err = 0;

  assign tx_done_tick = model_tick | spur_tick;

  uart_tx_fifo_ctrl #(.DBIT(8), .ADDR_W(4)) dut (
    .clk          (clk),
    .reset        (reset),
    .wr           (wr),
    .w_data       (w_data),
    .tx_done_tick (tx_done_tick),
    .tx_start     (tx_start),
    .tx_din       (tx_din),
    .full         (full),
    .empty        (empty),
    .count        (count),
    .busy         (busy),
    .overflow     (overflow)
  );

  always #5 clk = ~clk;

  // Launch monitor: record every launched byte and any back-to-back tx_start.
  always @(negedge clk) begin
    if (tx_start) begin
      seen.push_back(tx_din);
      if (prev_start) dbl_err++;
    end
    prev_start = tx_start;
  end

  // Transmitter model: done tick tx_delay cycles after a launch, held off while stalled.
  initial begin
    int n;
    model_tick = 1'b0;
    forever begin
      @(negedge clk);
      if (tx_start && !model_off) begin
        n = 0;
        while (n < tx_delay || stall) begin
          @(negedge clk);
          n++;
        end
        model_tick = 1'b1;
        @(negedge clk);
        model_tick = 1'b0;
      end
    end
  end

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_cmp++;
    if (got !== exp) begin
      n_bad++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
    end
  endtask

  task automatic cyc(input int n);
    repeat (n) @(negedge clk);
  endtask

  task automatic wr_byte(input logic [7:0] b);
    wr = 1'b1;
    w_data = b;
    @(negedge clk);
    wr = 1'b0;
  endtask

  task automatic drain(input string tag, input int max);
    int n;
    n = 0;
    while ((busy || !empty) && n < max) begin
      @(negedge clk);
      n++;
    end
    chk(tag, {31'd0, (busy || !empty)}, 32'd0);
  endtask

  initial begin
    int base;
    int cnt;
    reset = 1'b0; wr = 1'b0; w_data = 8'h00;
    spur_tick = 1'b0; stall = 1'b0; model_off = 1'b0; tx_delay = 160;

    // reset state
    cyc(2);
    chk("rst_empty", empty, 1);
    chk("rst_full", full, 0);
    chk("rst_count", count, 0);
    chk("rst_start", tx_start, 0);
    chk("rst_busy", busy, 0);
    chk("rst_ovf", overflow, 0);
    chk("rst_din", tx_din, 0);
    reset = 1'b1;
    cyc(2);

    // single byte latency and 160-cycle frame
    wr_byte(8'h55);
    chk("t2_cnt1", count, 1);
    chk("t2_start_k0", tx_start, 0);
    cyc(1);
    chk("t2_start_k1", tx_start, 0);
    cyc(1);
    chk("t2_start_k2", tx_start, 1);
    chk("t2_din", tx_din, 8'h55);
    chk("t2_cnt_launch", count, 0);
    chk("t2_busy", busy, 1);
    cyc(1);
    chk("t2_start_off", tx_start, 0);
    chk("t2_din_hold", tx_din, 8'h55);
    cnt = 1;
    while (busy && cnt < 400) begin
      @(negedge clk);
      cnt++;
    end
    chk("t2_busy_fall", cnt, 161);

    // burst of 18 writes with the transmitter stalled
    tx_delay = 5;
    stall = 1'b1;
    base = seen.size();
    for (int i = 0; i < 18; i++) begin
      wr = 1'b1;
      w_data = (i < 17) ? 8'(i + 1) : 8'hAA;
      @(negedge clk);
      if (i == 15) begin
        chk("t3_cnt15", count, 15);
        chk("t3_notfull", full, 0);
      end
      if (i == 16) begin
        chk("t3_full", full, 1);
        chk("t3_cnt16", count, 16);
        chk("t3_no_ovf", overflow, 0);
      end
      if (i == 17) begin
        chk("t3_ovf", overflow, 1);
        chk("t3_cnt_hold", count, 16);
      end
    end
    wr = 1'b0;
    stall = 1'b0;
    drain("t3_drain", 2000);
    chk("t3_nbytes", seen.size() - base, 17);
    for (int i = 0; i < 17; i++)
      if (base + i < seen.size()) chk($sformatf("t3_byte%0d", i), seen[base + i], i + 1);

    // write coinciding with the LAUNCH pop, count=3
    model_off = 1'b1;
    base = seen.size();
    wr_byte(8'h21);
    cyc(3);
    chk("t4_busy", busy, 1);
    wr_byte(8'h22);
    wr_byte(8'h23);
    wr_byte(8'h24);
    chk("t4_cnt3", count, 3);
    spur_tick = 1'b1;
    @(negedge clk);
    spur_tick = 1'b0;
    @(negedge clk);
    model_off = 1'b0;
    wr = 1'b1;
    w_data = 8'h25;
    @(negedge clk);
    wr = 1'b0;
    chk("t4_launch", tx_start, 1);
    chk("t4_din", tx_din, 8'h22);
    chk("t4_cnt_same", count, 3);
    drain("t4_drain", 500);
    chk("t4_nbytes", seen.size() - base, 5);
    for (int i = 0; i < 5; i++)
      if (base + i < seen.size()) chk($sformatf("t4_byte%0d", i), seen[base + i], 8'h21 + i);

    // spurious done tick while idle and empty
    base = seen.size();
    spur_tick = 1'b1;
    @(negedge clk);
    spur_tick = 1'b0;
    cyc(5);
    chk("t5_nostart", seen.size() - base, 0);
    chk("t5_cnt", count, 0);
    chk("t5_empty", empty, 1);
    chk("t5_busy", busy, 0);

    // reset while BUSY with bytes stored
    stall = 1'b1;
    wr_byte(8'h31);
    wr_byte(8'h32);
    wr_byte(8'h33);
    wr_byte(8'h34);
    cyc(2);
    chk("t6_busy", busy, 1);
    chk("t6_cnt3", count, 3);
    chk("t6_ovf_sticky", overflow, 1);
    reset = 1'b0;
    @(negedge clk);
    reset = 1'b1;
    chk("t6_cnt", count, 0);
    chk("t6_busy_clr", busy, 0);
    chk("t6_empty", empty, 1);
    chk("t6_ovf_clr", overflow, 0);
    chk("t6_start", tx_start, 0);
    base = seen.size();
    stall = 1'b0;
    cyc(20);
    chk("t6_nostart", seen.size() - base, 0);
    chk("t6_cnt_after", count, 0);
    chk("t6_busy_after", busy, 0);

    chk("dbl_start", dbl_err, 0);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL timeout: got running expected finished");
    $fatal(1);
  end

endmodule
